gpo_pad_ctrl: RTL and testbench

//  Digital-side controller directly upstream of the EG1 1.8V GPO pad cell; drives DO/DS/SR/CO/OE/ODP/ODN.

---
 rtl/gpo_pad_ctrl_pkg.sv | 55 +++++
 rtl/gpo_pad_ctrl_pulse_gen.sv | 55 +++++
 rtl/gpo_pad_ctrl.sv | 148 ++++++++++++++
 tb/tb_gpo_pad_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpo_pad_ctrl_pkg.sv
// Shared types and helpers for the EG1 1.8V GPO pad controller.
package gpo_pad_ctrl_pkg;

   localparam int DS_W = 4;

   typedef enum logic [1:0] {
      ST_STABLE  = 2'b00,
      ST_QUIESCE = 2'b01,
      ST_SETTLE  = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      OD_PUSH_PULL   = 2'b00,
      OD_OPEN_DRAIN  = 2'b01,
      OD_OPEN_SOURCE = 2'b10,
      OD_OFF         = 2'b11
   } od_mode_e;

   typedef struct packed {
      logic [DS_W-1:0] ds;
      logic            sr;
      logic            co;
      od_mode_e        od_mode;
      logic            oe;
   } shadow_cfg_t;

   localparam shadow_cfg_t SHADOW_RST = '{ds: 4'b0000, sr: 1'b0, co: 1'b0,
                                          od_mode: OD_PUSH_PULL, oe: 1'b0};

   // The pad only honours OE at a non-zero low drive-strength code when VBIAS is valid.
   function automatic logic bias_needed(input logic [DS_W-1:0] ds);
      return (ds[1:0] != 2'b00);
   endfunction

   function automatic logic od_to_odp(input od_mode_e mode);
      logic odp;
      case (mode)
         OD_OPEN_DRAIN: odp = 1'b1;
         OD_OFF:        odp = 1'b1;
         default:       odp = 1'b0;
      endcase
      return odp;
   endfunction

   function automatic logic od_to_odn(input od_mode_e mode);
      logic odn;
      case (mode)
         OD_OPEN_SOURCE: odn = 1'b1;
         OD_OFF:         odn = 1'b1;
         default:        odn = 1'b0;
      endcase
      return odn;
   endfunction

endpackage

// File: rtl/gpo_pad_ctrl_pulse_gen.sv
// Fixed-length high pulse generator for do_o; present only with GPO_PAD_CTRL_PULSE_EN.
`ifdef GPO_PAD_CTRL_PULSE_EN
module gpo_pulse_gen #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic             abort_i,
   output logic             active_o,
   output logic             active_nxt_o
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;

   // cnt_r holds the number of forced cycles still to go, including the current one
   always_comb begin
      active_nxt_o = active_o;
      cnt_nxt_s    = cnt_r;
      if (abort_i) begin
         active_nxt_o = 1'b0;
         cnt_nxt_s    = CNT_ZERO;
      end else if (active_o) begin
         if (cnt_r <= CNT_ONE) begin
            active_nxt_o = 1'b0;
            cnt_nxt_s    = CNT_ZERO;
         end else begin
            cnt_nxt_s = cnt_r - CNT_ONE;
         end
      end else if (start_i && (len_i != CNT_ZERO)) begin
         active_nxt_o = 1'b1;
         cnt_nxt_s    = len_i;
      end else begin
         active_nxt_o = 1'b0;
      end
   end

   // Pulse state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active_o <= 1'b0;
         cnt_r    <= CNT_ZERO;
      end else begin
         active_o <= active_nxt_o;
         cnt_r    <= cnt_nxt_s;
      end
   end

endmodule
`endif

// File: rtl/gpo_pad_ctrl.sv
// GPO pad controller: registered data path plus glitch-free OE-off/apply/settle/OE-on reconfiguration.
// Optional feature macro: GPO_PAD_CTRL_PULSE_EN (fixed-length forced-high pulse on do_o).
module gpo_pad_ctrl
   import gpo_pad_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            data_i,
   input  logic            cfg_valid_i,
   output logic            cfg_ready_o,
   input  logic [DS_W-1:0] cfg_ds_i,
   input  logic            cfg_sr_i,
   input  logic            cfg_co_i,
   input  logic [1:0]      cfg_od_mode_i,
   input  logic            cfg_oe_i,
   input  logic            vbias_ok_i,
`ifdef GPO_PAD_CTRL_PULSE_EN
   input  logic             pulse_start_i,
   input  logic [CNT_W-1:0] pulse_len_i,
   output logic             pulse_active_o,
`endif
   output logic            do_o,
   output logic [DS_W-1:0] ds_o,
   output logic            sr_o,
   output logic            co_o,
   output logic            oe_o,
   output logic            odp_o,
   output logic            odn_o,
   output logic            busy_o,
   output logic            err_o
);

   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE_CYCLES);

   state_e          state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   shadow_cfg_t     shadow_r, shadow_nxt_s;
   logic [DS_W-1:0] ds_nxt_s;
   logic            sr_nxt_s, co_nxt_s, oe_nxt_s, odp_nxt_s, odn_nxt_s, err_nxt_s;
   logic            accept_s;
   logic            pulse_force_s;

   assign cfg_ready_o = (state_r == ST_STABLE);
   assign busy_o      = ~cfg_ready_o;
   assign accept_s    = cfg_valid_i & cfg_ready_o;

`ifdef GPO_PAD_CTRL_PULSE_EN
   gpo_pulse_gen #(.CNT_W(CNT_W)) u_pulse_gen (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (pulse_start_i & cfg_ready_o),
      .len_i        (pulse_len_i),
      .abort_i      (accept_s),
      .active_o     (pulse_active_o),
      .active_nxt_o (pulse_force_s)
   );
`else
   assign pulse_force_s = 1'b0;
`endif

   // Reconfiguration sequencer: pad config only moves while oe_o is held low
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      shadow_nxt_s = shadow_r;
      ds_nxt_s     = ds_o;
      sr_nxt_s     = sr_o;
      co_nxt_s     = co_o;
      odp_nxt_s    = odp_o;
      odn_nxt_s    = odn_o;
      oe_nxt_s     = oe_o;
      err_nxt_s    = err_o;
      case (state_r)
         ST_STABLE: begin
            if (accept_s) begin
               shadow_nxt_s = '{ds: cfg_ds_i, sr: cfg_sr_i, co: cfg_co_i,
                                od_mode: od_mode_e'(cfg_od_mode_i), oe: cfg_oe_i};
               err_nxt_s    = 1'b0;
               oe_nxt_s     = 1'b0;
               state_nxt_s  = ST_QUIESCE;
            end else if (oe_o && bias_needed(ds_o) && !vbias_ok_i) begin
               oe_nxt_s  = 1'b0;
               err_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ST_STABLE;
            end
         end
         ST_QUIESCE: begin
            ds_nxt_s    = shadow_r.ds;
            sr_nxt_s    = shadow_r.sr;
            co_nxt_s    = shadow_r.co;
            odp_nxt_s   = od_to_odp(shadow_r.od_mode);
            odn_nxt_s   = od_to_odn(shadow_r.od_mode);
            cnt_nxt_s   = CNT_SETTLE;
            state_nxt_s = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_r != CNT_ZERO) begin
               cnt_nxt_s = cnt_r - CNT_ONE;
            end else begin
               state_nxt_s = ST_STABLE;
               oe_nxt_s    = shadow_r.oe & (~bias_needed(ds_o) | vbias_ok_i);
               err_nxt_s   = err_o | (shadow_r.oe & ~vbias_ok_i & bias_needed(ds_o));
            end
         end
         default: begin
            state_nxt_s = ST_STABLE;
            cnt_nxt_s   = CNT_ZERO;
            oe_nxt_s    = 1'b0;
         end
      endcase
   end

   // State, shadow config and pad output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r  <= ST_STABLE;
         cnt_r    <= CNT_ZERO;
         shadow_r <= SHADOW_RST;
         do_o     <= 1'b0;
         ds_o     <= 4'b0000;
         sr_o     <= 1'b0;
         co_o     <= 1'b0;
         oe_o     <= 1'b0;
         odp_o    <= 1'b0;
         odn_o    <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         shadow_r <= shadow_nxt_s;
         do_o     <= data_i | pulse_force_s;
         ds_o     <= ds_nxt_s;
         sr_o     <= sr_nxt_s;
         co_o     <= co_nxt_s;
         oe_o     <= oe_nxt_s;
         odp_o    <= odp_nxt_s;
         odn_o    <= odn_nxt_s;
         err_o    <= err_nxt_s;
      end
   end

endmodule

// File: tb/tb_gpo_pad_ctrl.sv
// Directed self-checking bench for gpo_pad_ctrl (SETTLE_CYCLES=4); pulse scenarios need GPO_PAD_CTRL_PULSE_EN.
module tb_gpo_pad_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       data_i;
   logic       cfg_valid_i;
   logic       cfg_ready_o;
   logic [3:0] cfg_ds_i;
   logic       cfg_sr_i;
   logic       cfg_co_i;
   logic [1:0] cfg_od_mode_i;
   logic       cfg_oe_i;
   logic       vbias_ok_i;
   logic       do_o, sr_o, co_o, oe_o, odp_o, odn_o, busy_o, err_o;
   logic [3:0] ds_o;
`ifdef GPO_PAD_CTRL_PULSE_EN
   logic       pulse_start_i;
   logic [7:0] pulse_len_i;
   logic       pulse_active_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   gpo_pad_ctrl #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .data_i        (data_i),
      .cfg_valid_i   (cfg_valid_i),
      .cfg_ready_o   (cfg_ready_o),
      .cfg_ds_i      (cfg_ds_i),
      .cfg_sr_i      (cfg_sr_i),
      .cfg_co_i      (cfg_co_i),
      .cfg_od_mode_i (cfg_od_mode_i),
      .cfg_oe_i      (cfg_oe_i),
      .vbias_ok_i    (vbias_ok_i),
`ifdef GPO_PAD_CTRL_PULSE_EN
      .pulse_start_i (pulse_start_i),
      .pulse_len_i   (pulse_len_i),
      .pulse_active_o(pulse_active_o),
`endif
      .do_o          (do_o),
      .ds_o          (ds_o),
      .sr_o          (sr_o),
      .co_o          (co_o),
      .oe_o          (oe_o),
      .odp_o         (odp_o),
      .odn_o         (odn_o),
      .busy_o        (busy_o),
      .err_o         (err_o)
   );

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic offer(input logic [3:0] ds, input logic sr, input logic co,
                        input logic [1:0] od, input logic oe);
      cfg_ds_i      = ds;
      cfg_sr_i      = sr;
      cfg_co_i      = co;
      cfg_od_mode_i = od;
      cfg_oe_i      = oe;
      cfg_valid_i   = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      for (int c = 0; c < 20 && busy_o; c++) tick();
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL %s idle timeout busy=%b exp 0", name, busy_o);
      end
   endtask

   task automatic test_reset();
      logic [11:0] obs;
      rst_ni = 1'b0;
      data_i = 1'b1;
      vbias_ok_i = 1'b1;
      #12;
      obs = {do_o, oe_o, ds_o, sr_o, co_o, odp_o, odn_o, busy_o, err_o};
      checks++;
      if (obs !== 12'b0 || cfg_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_init outs=%b ready=%b exp 0/1", obs, cfg_ready_o);
      end
      tick();
      rst_ni = 1'b1;
      tick();
      // reset in the middle of SETTLE
      offer(4'b0101, 1'b1, 1'b1, 2'b11, 1'b1);
      tick();
      cfg_valid_i = 1'b0;
      tick();
      tick();
      checks++;
      if ({ds_o, busy_o, do_o, odp_o} !== 7'b0101_1_1_1) begin
         errors++;
         $display("FAIL reset_pre ds/busy/do/odp=%b exp 0101111", {ds_o, busy_o, do_o, odp_o});
      end
      #2 rst_ni = 1'b0;
      #1;
      obs = {do_o, oe_o, ds_o, sr_o, co_o, odp_o, odn_o, busy_o, err_o};
      checks++;
      if (obs !== 12'b0 || cfg_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid outs=%b ready=%b exp 0/1", obs, cfg_ready_o);
      end
      tick();
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_cfg_apply();
      vbias_ok_i = 1'b1;
      offer(4'b0001, 1'b0, 1'b0, 2'b00, 1'b1);
      tick();
      cfg_valid_i = 1'b0;
      checks++;
      if ({oe_o, busy_o, cfg_ready_o} !== 3'b010) begin
         errors++;
         $display("FAIL apply_e0 oe/busy/ready=%b exp 010", {oe_o, busy_o, cfg_ready_o});
      end
      tick();
      checks++;
      if ({ds_o, oe_o} !== 5'b0001_0) begin
         errors++;
         $display("FAIL apply_e1 ds/oe=%b exp 00010", {ds_o, oe_o});
      end
      repeat (4) tick();
      checks++;
      if ({oe_o, busy_o} !== 2'b01) begin
         errors++;
         $display("FAIL apply_e5 oe/busy=%b exp 01", {oe_o, busy_o});
      end
      tick();
      checks++;
      if ({oe_o, busy_o, err_o, cfg_ready_o} !== 4'b1001) begin
         errors++;
         $display("FAIL apply_e6 oe/busy/err/ready=%b exp 1001", {oe_o, busy_o, err_o, cfg_ready_o});
      end
   endtask

   task automatic test_vbias_missing();
      vbias_ok_i = 1'b0;
      offer(4'b0001, 1'b0, 1'b0, 2'b00, 1'b1);
      tick();
      cfg_valid_i = 1'b0;
      checks++;
      if ({oe_o, err_o, busy_o} !== 3'b001) begin
         errors++;
         $display("FAIL nobias_e0 oe/err/busy=%b exp 001", {oe_o, err_o, busy_o});
      end
      repeat (6) tick();
      checks++;
      if ({oe_o, err_o, busy_o} !== 3'b010) begin
         errors++;
         $display("FAIL nobias_e6 oe/err/busy=%b exp 010", {oe_o, err_o, busy_o});
      end
      offer(4'b0000, 1'b0, 1'b0, 2'b00, 1'b1);
      tick();
      cfg_valid_i = 1'b0;
      checks++;
      if ({err_o, busy_o} !== 2'b01) begin
         errors++;
         $display("FAIL nobias_clr err/busy=%b exp 01", {err_o, busy_o});
      end
      tick();
      checks++;
      if (ds_o !== 4'b0000) begin
         errors++;
         $display("FAIL nobias_ds0 ds=%b exp 0000", ds_o);
      end
      repeat (5) tick();
      checks++;
      if ({oe_o, err_o} !== 2'b10) begin
         errors++;
         $display("FAIL nobias_ds0_oe oe/err=%b exp 10", {oe_o, err_o});
      end
   endtask

   task automatic test_vbias_drop();
      vbias_ok_i = 1'b1;
      offer(4'b0010, 1'b0, 1'b0, 2'b00, 1'b1);
      tick();
      cfg_valid_i = 1'b0;
      repeat (6) tick();
      checks++;
      if (oe_o !== 1'b1) begin
         errors++;
         $display("FAIL drop_pre oe=%b exp 1", oe_o);
      end
      vbias_ok_i = 1'b0;
      tick();
      checks++;
      if ({oe_o, err_o} !== 2'b01) begin
         errors++;
         $display("FAIL drop_edge oe/err=%b exp 01", {oe_o, err_o});
      end
      vbias_ok_i = 1'b1;
      repeat (3) tick();
      checks++;
      if ({oe_o, err_o} !== 2'b01) begin
         errors++;
         $display("FAIL drop_noreen oe/err=%b exp 01", {oe_o, err_o});
      end
   endtask

   task automatic test_back_to_back();
      vbias_ok_i = 1'b1;
      offer(4'b0001, 1'b1, 1'b0, 2'b00, 1'b1);
      tick();
      offer(4'b0100, 1'b0, 1'b1, 2'b00, 1'b1);
      tick();
      checks++;
      if ({ds_o, sr_o, co_o, busy_o} !== 7'b0001_1_0_1) begin
         errors++;
         $display("FAIL b2b_e1 ds/sr/co/busy=%b exp 0001101", {ds_o, sr_o, co_o, busy_o});
      end
      repeat (5) tick();
      checks++;
      if ({oe_o, busy_o, ds_o} !== 6'b1_0_0001) begin
         errors++;
         $display("FAIL b2b_e6 oe/busy/ds=%b exp 100001", {oe_o, busy_o, ds_o});
      end
      tick();
      cfg_valid_i = 1'b0;
      checks++;
      if ({busy_o, oe_o, ds_o} !== 6'b1_0_0001) begin
         errors++;
         $display("FAIL b2b_e7 busy/oe/ds=%b exp 100001", {busy_o, oe_o, ds_o});
      end
      tick();
      checks++;
      if ({ds_o, sr_o, co_o} !== 6'b0100_0_1) begin
         errors++;
         $display("FAIL b2b_e8 ds/sr/co=%b exp 010001", {ds_o, sr_o, co_o});
      end
      repeat (5) tick();
      checks++;
      if ({oe_o, busy_o} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_e13 oe/busy=%b exp 10", {oe_o, busy_o});
      end
   endtask

   task automatic test_od_modes();
      logic [1:0] modes [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
      logic [1:0] exps  [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
      for (int i = 0; i < 4; i++) begin
         offer(4'b0000, 1'b0, 1'b0, modes[i], 1'b0);
         tick();
         cfg_valid_i = 1'b0;
         tick();
         checks++;
         if ({odp_o, odn_o} !== exps[i]) begin
            errors++;
            $display("FAIL od_mode_%b odp/odn=%b exp %b", modes[i], {odp_o, odn_o}, exps[i]);
         end
         wait_idle("od_mode");
      end
   endtask

   task automatic test_data();
      logic [7:0] pat = 8'b1011_0010;
      for (int i = 0; i < 8; i++) begin
         data_i = pat[i];
         #1;
         if (i > 0) begin
            checks++;
            if (do_o !== pat[i-1]) begin
               errors++;
               $display("FAIL data_hold%0d do=%b exp %b", i, do_o, pat[i-1]);
            end
         end
         tick();
         checks++;
         if (do_o !== pat[i]) begin
            errors++;
            $display("FAIL data_%0d do=%b exp %b", i, do_o, pat[i]);
         end
      end
   endtask

`ifdef GPO_PAD_CTRL_PULSE_EN
   task automatic test_pulse();
      data_i = 1'b0;
      pulse_len_i = 8'd3;
      pulse_start_i = 1'b1;
      tick();
      pulse_start_i = 1'b0;
      checks++;
      if ({do_o, pulse_active_o} !== 2'b11) begin
         errors++;
         $display("FAIL pulse_c1 do/act=%b exp 11", {do_o, pulse_active_o});
      end
      pulse_len_i = 8'd5;
      pulse_start_i = 1'b1;
      tick();
      pulse_start_i = 1'b0;
      tick();
      checks++;
      if ({do_o, pulse_active_o} !== 2'b11) begin
         errors++;
         $display("FAIL pulse_c3 do/act=%b exp 11", {do_o, pulse_active_o});
      end
      tick();
      checks++;
      if ({do_o, pulse_active_o} !== 2'b00) begin
         errors++;
         $display("FAIL pulse_end do/act=%b exp 00", {do_o, pulse_active_o});
      end
      pulse_len_i = 8'd0;
      pulse_start_i = 1'b1;
      tick();
      pulse_start_i = 1'b0;
      checks++;
      if ({do_o, pulse_active_o} !== 2'b00) begin
         errors++;
         $display("FAIL pulse_len0 do/act=%b exp 00", {do_o, pulse_active_o});
      end
      pulse_len_i = 8'd10;
      pulse_start_i = 1'b1;
      tick();
      pulse_start_i = 1'b0;
      tick();
      offer(4'b0000, 1'b0, 1'b0, 2'b00, 1'b0);
      tick();
      cfg_valid_i = 1'b0;
      checks++;
      if ({do_o, pulse_active_o} !== 2'b00) begin
         errors++;
         $display("FAIL pulse_abort do/act=%b exp 00", {do_o, pulse_active_o});
      end
      wait_idle("pulse_abort");
   endtask
`endif

   initial begin
      cfg_valid_i = 1'b0;
      cfg_ds_i = 4'b0000;
      cfg_sr_i = 1'b0;
      cfg_co_i = 1'b0;
      cfg_od_mode_i = 2'b00;
      cfg_oe_i = 1'b0;
      vbias_ok_i = 1'b1;
      data_i = 1'b0;
`ifdef GPO_PAD_CTRL_PULSE_EN
      pulse_start_i = 1'b0;
      pulse_len_i = 8'd0;
`endif
      test_reset();
      test_cfg_apply();
      test_vbias_missing();
      test_vbias_drop();
      test_back_to_back();
      test_od_modes();
      test_data();
`ifdef GPO_PAD_CTRL_PULSE_EN
      test_pulse();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
